cpu6_branchres: RTL and testbench

Branch resolution and redirect unit for the cpu6 execute stage. It produces the `zero`/`lt` comparison flags from the branch operands, forms the taken/not-taken decision, and compares it with the fetch-stage prediction. On a mispredict it registers a PC redirect toward fetch, holding it with a valid/ready handshake, and emits a one-cycle pipeline flush. It sits between the EX operand bypass and the fetch PC mux.

---
 rtl/cpu6_branchres_pkg.sv | 17 +
 rtl/cpu6_branchres_branchdec.sv | 22 ++
 rtl/cpu6_branchres.sv | 106 ++++++++++
 tb/tb_cpu6_branchres.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu6_branchres_pkg.sv
// Shared encodings for the cpu6 branch resolution unit: branch types and FSM states.
package cpu6_branchres_pkg;

  localparam int CPU6_BRANCHTYPE_SIZE = 3;

  localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_BRANCHTYPE_NONE = 3'd0;
  localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_BRANCHTYPE_BEQ  = 3'd1;
  localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_BRANCHTYPE_BNE  = 3'd2;
  localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_BRANCHTYPE_BLTU = 3'd3;
  localparam logic [CPU6_BRANCHTYPE_SIZE-1:0] CPU6_BRANCHTYPE_BGEU = 3'd4;

  typedef enum logic {
    CPU6_BRRES_IDLE  = 1'b0,
    CPU6_BRRES_REDIR = 1'b1
  } brres_state_e;

endpackage

// File: rtl/cpu6_branchres_branchdec.sv
// cpu6_branchdec: taken decision from branch type and the zero/lt comparison flags.
module cpu6_branchdec
  import cpu6_branchres_pkg::*;
(
  input  logic [CPU6_BRANCHTYPE_SIZE-1:0] branchtype,
  input  logic                            zero,
  input  logic                            lt,
  output logic                            taken
);

  always_comb begin
    taken = 1'b0;
    case (branchtype)
      CPU6_BRANCHTYPE_BEQ:  taken = zero;
      CPU6_BRANCHTYPE_BNE:  taken = ~zero;
      CPU6_BRANCHTYPE_BLTU: taken = lt;
      CPU6_BRANCHTYPE_BGEU: taken = ~lt;
      default:              taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu6_branchres.sv
// Branch resolution and redirect unit for the cpu6 EX stage.
// Optional branch statistics counters are built when CPU6_BRANCH_STATS_EN is defined.
module cpu6_branchres
  import cpu6_branchres_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ex_valid,
  output logic                            ex_ready,
  input  logic [CPU6_BRANCHTYPE_SIZE-1:0] ex_branchtype,
  input  logic [DATA_W-1:0]               ex_rs1,
  input  logic [DATA_W-1:0]               ex_rs2,
  input  logic [PC_W-1:0]                 ex_pc,
  input  logic [PC_W-1:0]                 ex_imm,
  input  logic                            ex_pred_taken,
  output logic                            redirect_valid,
  output logic [PC_W-1:0]                 redirect_pc,
  input  logic                            redirect_ready,
  output logic                            flush,
  output logic [31:0]                     stat_branches,
  output logic [31:0]                     stat_mispredicts
);

  brres_state_e    state_q;
  logic [PC_W-1:0] redirect_pc_q;
  logic            flush_q;

  logic            zero;
  logic            lt;
  logic            taken;
  logic            is_branch;
  logic            accept;
  logic            mispredict;
  logic [PC_W-1:0] target;

  assign zero = (ex_rs1 == ex_rs2);
  assign lt   = (ex_rs1 < ex_rs2);

  cpu6_branchdec u_branchdec (
    .branchtype (ex_branchtype),
    .zero       (zero),
    .lt         (lt),
    .taken      (taken)
  );

  assign is_branch  = (ex_branchtype != CPU6_BRANCHTYPE_NONE);
  assign accept     = ex_valid & ex_ready;
  assign mispredict = is_branch & (taken ^ ex_pred_taken);
  // Both sums wrap modulo 2^PC_W by construction.
  assign target     = taken ? (ex_pc + ex_imm) : (ex_pc + PC_W'(4));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CPU6_BRRES_IDLE;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        CPU6_BRRES_IDLE: begin
          if (accept && mispredict) begin
            redirect_pc_q <= target;
            flush_q       <= 1'b1;
            state_q       <= CPU6_BRRES_REDIR;
          end
        end
        CPU6_BRRES_REDIR: begin
          if (redirect_ready) state_q <= CPU6_BRRES_IDLE;
        end
        default: state_q <= CPU6_BRRES_IDLE;
      endcase
    end
  end

  assign ex_ready       = (state_q == CPU6_BRRES_IDLE);
  assign redirect_valid = (state_q == CPU6_BRRES_REDIR);
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;

`ifdef CPU6_BRANCH_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  // Saturating counters; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (accept && is_branch) begin
      if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict && stat_mispredicts_q != 32'hFFFF_FFFF)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_cpu6_branchres.sv
// Directed self-checking bench for cpu6_branchres (honours CPU6_BRANCH_STATS_EN if defined).
module tb_cpu6_branchres;
  import cpu6_branchres_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  ex_branchtype;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_imm;
  logic        ex_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        flush;
  logic [31:0] stat_branches, stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu6_branchres #(.PC_W(32), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_branchtype    (ex_branchtype),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_ready   (redirect_ready),
    .flush            (flush),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] bt, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    ex_valid      = v;
    ex_branchtype = bt;
    ex_rs1        = rs1;
    ex_rs2        = rs2;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_pred_taken = pred;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_ready = 1'b0;
    drive(1'b0, CPU6_BRANCHTYPE_NONE, 0, 0, 0, 0, 1'b0);
    tick();
    tick();
    check_eq("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst_flush", {31'd0, flush}, 32'd0);
    check_eq("rst_rpc", redirect_pc, 32'd0);
    check_eq("rst_stat_br", stat_branches, 32'd0);
    check_eq("rst_stat_mp", stat_mispredicts, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rst_ready", {31'd0, ex_ready}, 32'd1);

    // BEQ taken, predicted not taken: redirect to pc+imm.
    tick();
    drive(1'b1, CPU6_BRANCHTYPE_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
    tick();
    drive(1'b0, CPU6_BRANCHTYPE_NONE, 0, 0, 0, 0, 1'b0);
    check_eq("beq_flush", {31'd0, flush}, 32'd1);
    check_eq("beq_rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("beq_rpc", redirect_pc, 32'h120);
    check_eq("beq_ready", {31'd0, ex_ready}, 32'd0);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check_eq("beq_hs_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("beq_hs_flush", {31'd0, flush}, 32'd0);
    check_eq("beq_hs_ready", {31'd0, ex_ready}, 32'd1);

    // BLTU unsigned not taken vs pred taken; redirect_ready high in IDLE is ignored.
    drive(1'b1, CPU6_BRANCHTYPE_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b1);
    redirect_ready = 1'b1;
    tick();
    drive(1'b0, CPU6_BRANCHTYPE_NONE, 0, 0, 0, 0, 1'b0);
    check_eq("bltu_flush", {31'd0, flush}, 32'd1);
    check_eq("bltu_rv", {31'd0, redirect_valid}, 32'd1);
    check_eq("bltu_rpc", redirect_pc, 32'h204);
    tick();
    redirect_ready = 1'b0;
    check_eq("bltu_min_hs_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("bltu_flush_once", {31'd0, flush}, 32'd0);

    // Ten correctly predicted BNEs back to back.
    drive(1'b1, CPU6_BRANCHTYPE_BNE, 32'd3, 32'd4, 32'h300, 32'h8, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("bne%0d_ready", i), {31'd0, ex_ready}, 32'd1);
      tick();
      check_eq($sformatf("bne%0d_flush", i), {31'd0, flush}, 32'd0);
      check_eq($sformatf("bne%0d_rv", i), {31'd0, redirect_valid}, 32'd0);
    end

    // BGEU 1>=2 false, pred taken -> redirect pc+4; ready held off 5 cycles.
    drive(1'b1, CPU6_BRANCHTYPE_BGEU, 32'd1, 32'd2, 32'h300, 32'h80, 1'b1);
    tick();
    drive(1'b1, CPU6_BRANCHTYPE_BEQ, 32'd7, 32'd7, 32'h400, 32'h10, 1'b0);
    check_eq("bgeu_flush", {31'd0, flush}, 32'd1);
    check_eq("bgeu_rpc", redirect_pc, 32'h304);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("hold%0d_flush", i), {31'd0, flush}, 32'd0);
      check_eq($sformatf("hold%0d_rv", i), {31'd0, redirect_valid}, 32'd1);
      check_eq($sformatf("hold%0d_rpc", i), redirect_pc, 32'h304);
      check_eq($sformatf("hold%0d_ready", i), {31'd0, ex_ready}, 32'd0);
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check_eq("hold_done_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("hold_done_ready", {31'd0, ex_ready}, 32'd1);
    check_eq("hold_done_flush", {31'd0, flush}, 32'd0);
    tick();
    drive(1'b0, CPU6_BRANCHTYPE_NONE, 0, 0, 0, 0, 1'b0);
    check_eq("held_acc_flush", {31'd0, flush}, 32'd1);
    check_eq("held_acc_rpc", redirect_pc, 32'h410);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check_eq("held_hs_rv", {31'd0, redirect_valid}, 32'd0);

    // Wrap-around target, then reset while in REDIR.
    drive(1'b1, CPU6_BRANCHTYPE_BEQ, 32'd1, 32'd1, 32'hFFFF_FFF0, 32'h20, 1'b0);
    tick();
    drive(1'b0, CPU6_BRANCHTYPE_NONE, 0, 0, 0, 0, 1'b0);
    check_eq("wrap_rpc", redirect_pc, 32'h10);
    check_eq("wrap_rv", {31'd0, redirect_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("midrst_flush", {31'd0, flush}, 32'd0);
    check_eq("midrst_ready", {31'd0, ex_ready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check_eq("postrst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("postrst_flush", {31'd0, flush}, 32'd0);

    // Stats: 3 branches (1 mispredict) plus 2 NONE.
    drive(1'b1, CPU6_BRANCHTYPE_BEQ, 32'd1, 32'd1, 32'h500, 32'h10, 1'b1);
    tick();
    drive(1'b1, CPU6_BRANCHTYPE_NONE, 32'd1, 32'd1, 32'h504, 32'h10, 1'b1);
    tick();
    drive(1'b1, CPU6_BRANCHTYPE_BNE, 32'd1, 32'd2, 32'h508, 32'h10, 1'b1);
    tick();
    check_eq("none_noflush", {31'd0, flush}, 32'd0);
    drive(1'b1, CPU6_BRANCHTYPE_NONE, 32'd0, 32'd0, 32'h50C, 32'h10, 1'b0);
    tick();
    drive(1'b1, CPU6_BRANCHTYPE_BLTU, 32'd1, 32'd2, 32'h510, 32'h30, 1'b0);
    tick();
    drive(1'b0, CPU6_BRANCHTYPE_NONE, 0, 0, 0, 0, 1'b0);
    check_eq("st_flush", {31'd0, flush}, 32'd1);
    check_eq("st_rpc", redirect_pc, 32'h540);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
`ifdef CPU6_BRANCH_STATS_EN
    check_eq("stat_branches", stat_branches, 32'd3);
    check_eq("stat_mispredicts", stat_mispredicts, 32'd1);
`else
    check_eq("stat_branches", stat_branches, 32'd0);
    check_eq("stat_mispredicts", stat_mispredicts, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
